parking_exit_gate: RTL and testbench
====================================

// Module: parking_exit_gate
// PURPOSE
//  Exit-side barrier controller for the car park; the entry-gate controller's counterpart.
//  Detects a car at the inner exit loop, waits, checks a 2-bit exit code and opens the barrier.
//  Owns the lot occupancy count: entry pulses increment it, completed exits decrement it.
//  Sits beside the entry controller and drives the exit LEDs and exit display.
// PARAMETERS
//  EXIT_CODE      2'b01  code that opens the exit barrier
//  WAIT_CYCLES    4      cycles spent in WAIT before the code is sampled (>=1)
//  CAPACITY       15     maximum occupancy; increments saturate here
//  CNT_W          4      occupancy width; must satisfy CAPACITY < 2**CNT_W
//  TIMEOUT_CYCLES 16     OPEN-state timeout; used only with PARK_EXIT_TIMEOUT_EN
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      asynchronous reset, active-high
//  inner_sensor   in   1      car present at inner (lot-side) exit loop
//  outer_sensor   in   1      car present at outer (street-side) loop
//  exit_code      in   2      code from the exit keypad
//  entry_pulse    in   1      1-cycle pulse from entry gate: car entered
//  green_LED      out  1      go indicator
//  red_LED        out  1      stop/error indicator
//  display_screen out  4      exit status code
//  occupancy      out  CNT_W  cars currently in lot
//  lot_full       out  1      occupancy == CAPACITY
//  exit_pulse     out  1      1-cycle pulse: car completed exit
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; wait counter 0; all outputs 0; occupancy 0.
//  States: IDLE, WAIT, WRONG, OPEN, BLOCK. Next state is combinational; state is registered.
//  IDLE : inner_sensor=1 -> WAIT. Otherwise stay in IDLE.
//  WAIT : wait_cnt increments each cycle in WAIT and is cleared in every other state.
//         At wait_cnt == WAIT_CYCLES-1, sample exit_code: ==EXIT_CODE -> OPEN, else -> WRONG.
//  WRONG: exit_code==EXIT_CODE -> OPEN; else inner_sensor=0 (car reversed) -> IDLE; else stay.
//  OPEN : inner=1 & outer=1 (tailgater) -> BLOCK; outer=1 alone -> IDLE with exit;
//         otherwise stay in OPEN.
//  BLOCK: exit_code==EXIT_CODE -> OPEN; else stay.
//  Exit event: the OPEN->IDLE transition via outer_sensor. On that edge exit_pulse=1 for
//    exactly one cycle, and occupancy decrements.
//  Outputs are registered from the present state, so they are valid one cycle after the
//    state is entered:
//    IDLE  g=0      r=0      disp=4'b1000
//    WAIT  g=0      r=1      disp=4'b1001
//    WRONG g=0      r toggles disp=4'b1011
//    OPEN  g toggles r=0      disp=4'b1100
//    BLOCK g=0      r toggles disp=4'b1111
//  Occupancy: entry_pulse -> +1, saturating at CAPACITY. Exit event -> -1, saturating at 0
//    (an exit at 0 is still allowed).
//  Entry and exit in the same cycle -> occupancy unchanged. lot_full is a combinational
//    compare on the registered occupancy.
//  Reset mid-operation: state and occupancy drop to their reset values immediately; no
//    exit_pulse is produced.
// CONFIGURATION
//  PARK_EXIT_TIMEOUT_EN defined:
//    a counter runs in OPEN. If OPEN lasts TIMEOUT_CYCLES cycles without outer_sensor,
//    go to IDLE with no exit_pulse and no decrement.
//  PARK_EXIT_TIMEOUT_EN undefined:
//    OPEN holds indefinitely; no timeout counter is built.
// STRUCTURE
//  parking_pkg: state encodings and the 4-bit display codes, shared with the entry controller.
//  Sub-module parking_occupancy_counter holds the saturating up/down counter and lot_full
//    (inputs inc, dec; parameters CAPACITY, CNT_W).
// TESTING
//  1. Correct code: inner=1, exit_code=01 -> WAIT for 4 cycles -> OPEN; disp 1100;
//     outer=1 -> IDLE; exit_pulse for 1 cycle.
//  2. Wrong code: sample code=11 -> WRONG, disp 1011, red toggles each cycle;
//     then code=01 -> OPEN.
//  3. Occupancy limits: 16 entry_pulses -> occupancy=15, lot_full=1;
//     exit when occupancy=0 -> stays 0.
//  4. Simultaneous events: entry_pulse on the same cycle as the exit event,
//     occupancy=5 -> stays 5.
//  5. Tailgate: in OPEN, inner=1 & outer=1 -> BLOCK, disp 1111; code=01 -> OPEN.
//  6. Reset mid-operation: rst pulse in OPEN -> IDLE, outputs 0, occupancy 0.
//     With the macro defined: OPEN for 16 cycles -> IDLE, no exit_pulse.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared car-park gate definitions: FSM state encoding and the 4-bit status display codes.
// Used by both the entry and exit barrier controllers.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRONG = 3'd2,
        ST_OPEN  = 3'd3,
        ST_BLOCK = 3'd4
    } gate_state_t;

    localparam logic [3:0] DISP_IDLE  = 4'b1000;
    localparam logic [3:0] DISP_WAIT  = 4'b1001;
    localparam logic [3:0] DISP_WRONG = 4'b1011;
    localparam logic [3:0] DISP_OPEN  = 4'b1100;
    localparam logic [3:0] DISP_BLOCK = 4'b1111;

    function automatic logic [3:0] state_display(input gate_state_t s);
        logic [3:0] d;
        case (s)
            ST_IDLE:  d = DISP_IDLE;
            ST_WAIT:  d = DISP_WAIT;
            ST_WRONG: d = DISP_WRONG;
            ST_OPEN:  d = DISP_OPEN;
            ST_BLOCK: d = DISP_BLOCK;
            default:  d = DISP_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating up/down car counter for the lot; inc and dec together cancel out.
// full is a plain compare on the registered count.
module parking_occupancy_counter #(
    parameter int CAPACITY = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && !dec && (count_reg != CAP)) begin
            count_next = count_reg + ONE;
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == CAP);

endmodule

// File: rtl/parking_exit_gate.sv
// Exit-side barrier controller: code check, barrier FSM, and ownership of lot occupancy.
// Define PARK_EXIT_TIMEOUT_EN to let an unused open barrier fall back to IDLE.
module parking_exit_gate
    import parking_pkg::*;
#(
    parameter logic [1:0] EXIT_CODE      = 2'b01,
    parameter int          WAIT_CYCLES    = 4,
    parameter int          CAPACITY       = 15,
    parameter int          CNT_W          = 4,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inner_sensor,
    input  logic             outer_sensor,
    input  logic [1:0]       exit_code,
    input  logic             entry_pulse,
    output logic             green_LED,
    output logic             red_LED,
    output logic [3:0]       display_screen,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             exit_pulse
);

    generate
        if (CAPACITY < 1 || CAPACITY >= (2 ** CNT_W) || WAIT_CYCLES < 1 || TIMEOUT_CYCLES < 1)
        begin : g_param_check
            $error("parking_exit_gate: illegal parameter combination");
        end
    endgenerate

    localparam int             WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    gate_state_t       state_reg;
    gate_state_t       state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              green_reg;
    logic              red_reg;
    logic [3:0]        disp_reg;
    logic              exit_pulse_reg;

    logic code_ok;
    logic wait_done;
    logic exit_event;
    logic timeout_hit;

    assign code_ok   = (exit_code == EXIT_CODE);
    assign wait_done = (wait_cnt_reg == WAIT_LAST);

`ifdef PARK_EXIT_TIMEOUT_EN
    localparam int           TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] timeout_cnt_reg;

    // Counts consecutive OPEN cycles; any excursion (e.g. via BLOCK) restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == ST_OPEN && state_next == ST_OPEN) begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_ONE;
        end else begin
            timeout_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (timeout_cnt_reg == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        exit_event = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (inner_sensor) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = code_ok ? ST_OPEN : ST_WRONG;
                end
            end
            ST_WRONG: begin
                if (code_ok) begin
                    state_next = ST_OPEN;
                end else if (!inner_sensor) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OPEN: begin
                // Tailgater check wins over the normal exit.
                if (inner_sensor && outer_sensor) begin
                    state_next = ST_BLOCK;
                end else if (outer_sensor) begin
                    state_next = ST_IDLE;
                    exit_event = 1'b1;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BLOCK: begin
                if (code_ok) begin
                    state_next = ST_OPEN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            green_reg      <= 1'b0;
            red_reg        <= 1'b0;
            disp_reg       <= 4'b0000;
            exit_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= (state_reg == ST_WAIT && state_next == ST_WAIT)
                              ? wait_cnt_reg + WAIT_ONE : '0;
            exit_pulse_reg <= exit_event;
            disp_reg       <= state_display(state_reg);
            // Indicators follow the present state, so they lag state entry by one cycle.
            case (state_reg)
                ST_IDLE: begin
                    green_reg <= 1'b0;
                    red_reg   <= 1'b0;
                end
                ST_WAIT: begin
                    green_reg <= 1'b0;
                    red_reg   <= 1'b1;
                end
                ST_WRONG: begin
                    green_reg <= 1'b0;
                    red_reg   <= ~red_reg;
                end
                ST_OPEN: begin
                    green_reg <= ~green_reg;
                    red_reg   <= 1'b0;
                end
                ST_BLOCK: begin
                    green_reg <= 1'b0;
                    red_reg   <= ~red_reg;
                end
                default: begin
                    green_reg <= 1'b0;
                    red_reg   <= 1'b0;
                end
            endcase
        end
    end

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk   (clk),
        .rst   (rst),
        .inc   (entry_pulse),
        .dec   (exit_event),
        .count (occupancy),
        .full  (lot_full)
    );

    assign green_LED      = green_reg;
    assign red_LED        = red_reg;
    assign display_screen = disp_reg;
    assign exit_pulse     = exit_pulse_reg;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Directed bench for parking_exit_gate: a per-cycle vector table plus hand-written
// sequences for reset, occupancy saturation and the open-barrier hold/timeout.
module tb_parking_exit_gate;

    logic       clk;
    logic       rst;
    logic       inner_sensor;
    logic       outer_sensor;
    logic [1:0] exit_code;
    logic       entry_pulse;
    logic       green_LED;
    logic       red_LED;
    logic [3:0] display_screen;
    logic [3:0] occupancy;
    logic       lot_full;
    logic       exit_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    parking_exit_gate dut (
        .clk            (clk),
        .rst            (rst),
        .inner_sensor   (inner_sensor),
        .outer_sensor   (outer_sensor),
        .exit_code      (exit_code),
        .entry_pulse    (entry_pulse),
        .green_LED      (green_LED),
        .red_LED        (red_LED),
        .display_screen (display_screen),
        .occupancy      (occupancy),
        .lot_full       (lot_full),
        .exit_pulse     (exit_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       inner;
        logic       outer;
        logic [1:0] code;
        logic       entry;
        logic       g;
        logic       r;
        logic [3:0] disp;
        logic       pulse;
        logic [3:0] occ;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic i, input logic o, input logic [1:0] c,
                                input logic e, input logic g, input logic r,
                                input logic [3:0] d, input logic p, input logic [3:0] occ);
        vec_t v;
        v.inner = i; v.outer = o; v.code = c; v.entry = e;
        v.g = g; v.r = r; v.disp = d; v.pulse = p; v.occ = occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %-16s got %h", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic i, input logic o, input logic [1:0] c, input logic e);
        inner_sensor = i;
        outer_sensor = o;
        exit_code    = c;
        entry_pulse  = e;
        @(posedge clk);
        #1;
    endtask

    // From IDLE: one edge into WAIT, four WAIT cycles, leaves in OPEN.
    task automatic go_open();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 2'b01, 1'b0);
    endtask

    function automatic logic [11:0] pack_out();
        return {green_LED, red_LED, display_screen, exit_pulse, occupancy, lot_full};
    endfunction

    initial begin
        logic [11:0] exp_v;
        logic        saw_pulse;

        rst = 1'b1; inner_sensor = 1'b0; outer_sensor = 1'b0;
        exit_code = 2'b00; entry_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(pack_out()), 32'h0);
        rst = 1'b0;

        // inner outer code entry | g r disp pulse occ
        vq.push_back(mk(0,0,2'd0,1, 0,0,4'b1000,0,4'd1));
        vq.push_back(mk(0,0,2'd0,1, 0,0,4'b1000,0,4'd2));
        vq.push_back(mk(1,0,2'd1,0, 0,0,4'b1000,0,4'd2));
        vq.push_back(mk(1,0,2'd1,0, 0,1,4'b1001,0,4'd2));
        vq.push_back(mk(1,0,2'd1,0, 0,1,4'b1001,0,4'd2));
        vq.push_back(mk(1,0,2'd1,0, 0,1,4'b1001,0,4'd2));
        vq.push_back(mk(1,0,2'd1,0, 0,1,4'b1001,0,4'd2));
        vq.push_back(mk(0,0,2'd0,0, 1,0,4'b1100,0,4'd2));
        vq.push_back(mk(0,0,2'd0,0, 0,0,4'b1100,0,4'd2));
        vq.push_back(mk(0,1,2'd0,0, 1,0,4'b1100,1,4'd1));
        vq.push_back(mk(0,0,2'd0,0, 0,0,4'b1000,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,0,4'b1000,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,1,4'b1001,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,1,4'b1001,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,1,4'b1001,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,1,4'b1001,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,0,4'b1011,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,1,4'b1011,0,4'd1));
        vq.push_back(mk(1,0,2'd3,0, 0,0,4'b1011,0,4'd1));
        vq.push_back(mk(1,0,2'd1,0, 0,1,4'b1011,0,4'd1));
        vq.push_back(mk(0,0,2'd0,0, 1,0,4'b1100,0,4'd1));
        vq.push_back(mk(1,1,2'd0,0, 0,0,4'b1100,0,4'd1));
        vq.push_back(mk(1,1,2'd0,0, 0,1,4'b1111,0,4'd1));
        vq.push_back(mk(1,1,2'd0,0, 0,0,4'b1111,0,4'd1));
        vq.push_back(mk(0,0,2'd1,0, 0,1,4'b1111,0,4'd1));
        vq.push_back(mk(0,0,2'd0,1, 1,0,4'b1100,0,4'd2));
        vq.push_back(mk(0,0,2'd0,1, 0,0,4'b1100,0,4'd3));
        vq.push_back(mk(0,0,2'd0,1, 1,0,4'b1100,0,4'd4));
        vq.push_back(mk(0,0,2'd0,1, 0,0,4'b1100,0,4'd5));
        vq.push_back(mk(0,1,2'd0,1, 1,0,4'b1100,1,4'd5));
        vq.push_back(mk(0,0,2'd0,0, 0,0,4'b1000,0,4'd5));
        vq.push_back(mk(1,0,2'd0,0, 0,0,4'b1000,0,4'd5));
        vq.push_back(mk(1,0,2'd0,0, 0,1,4'b1001,0,4'd5));
        vq.push_back(mk(1,0,2'd0,0, 0,1,4'b1001,0,4'd5));
        vq.push_back(mk(1,0,2'd0,0, 0,1,4'b1001,0,4'd5));
        vq.push_back(mk(1,0,2'd0,0, 0,1,4'b1001,0,4'd5));
        vq.push_back(mk(0,0,2'd0,0, 0,0,4'b1011,0,4'd5));
        vq.push_back(mk(0,0,2'd0,0, 0,0,4'b1000,0,4'd5));

        foreach (vq[idx]) begin
            step(vq[idx].inner, vq[idx].outer, vq[idx].code, vq[idx].entry);
            exp_v = {vq[idx].g, vq[idx].r, vq[idx].disp, vq[idx].pulse, vq[idx].occ,
                     (vq[idx].occ == 4'd15)};
            check($sformatf("vec%0d", idx), 32'(pack_out()), 32'(exp_v));
        end

        // Asynchronous reset while the barrier is open.
        go_open();
        step(1'b0, 1'b0, 2'b00, 1'b0);
        #2 rst = 1'b1;
        #1 check("rst_async", 32'(pack_out()), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 2'b00, 1'b0);
        check("no_exit_after_rst", 32'(pack_out()), 32'({1'b0, 1'b0, 4'b1000, 1'b0, 4'd0, 1'b0}));

        // Fill the lot past capacity.
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 2'b00, 1'b1);
            if (k >= 14)
                check($sformatf("fill%0d", k), 32'({occupancy, lot_full}),
                      32'({(k >= 15) ? 4'd15 : 4'(k), (k >= 15)}));
        end
        go_open();
        step(1'b0, 1'b1, 2'b00, 1'b0);
        check("exit_from_full", 32'({exit_pulse, occupancy, lot_full}), 32'({1'b1, 4'd14, 1'b0}));
        step(1'b0, 1'b0, 2'b00, 1'b0);
        check("pulse_one_cycle", 32'(exit_pulse), 32'(1'b0));

        // Exit with an empty lot: pulse still fires, count stays at zero.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        go_open();
        step(1'b0, 1'b1, 2'b00, 1'b0);
        check("exit_at_zero", 32'({exit_pulse, occupancy}), 32'({1'b1, 4'd0}));

        // Leave the barrier open with no car leaving.
        step(1'b0, 1'b0, 2'b00, 1'b0);
        go_open();
        saw_pulse = 1'b0;
        for (int k = 0; k < 17; k++) begin
            step(1'b0, 1'b0, 2'b00, 1'b0);
            if (exit_pulse) saw_pulse = 1'b1;
        end
        check("open_hold_pulse", 32'({saw_pulse, occupancy}), 32'({1'b0, 4'd0}));
`ifdef PARK_EXIT_TIMEOUT_EN
        check("open_timeout", 32'(display_screen), 32'(4'b1000));
`else
        check("open_hold", 32'(display_screen), 32'(4'b1100));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
